// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter with packet lock that shares one
// serial transmit port between NREQ byte sources. The output byte is
// registered, and full rate is one byte per cycle.
module uart_tx_arbiter #(
  parameter int NREQ      = 2,   // 2..8; requester 0 comes first after reset
  parameter int MAX_BURST = 16   // 1..255 bytes per grant before forced release
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              forced_release
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [7:0]      burst_q, burst_d;
  logic [NREQ-1:0] grant_d;
  logic            forced_d;

  logic            load_en;
  logic            any_valid;
  logic [IW-1:0]   winner;
  logic [IW:0]     cand;
  logic [IW-1:0]   sel;
  logic [7:0]      sel_data;
  logic            sel_last;
  logic            transfer;

  // The output register can take a new byte when it is empty or draining this cycle
  assign load_en = !out_valid || out_ready;

  // Round-robin search: pick the first valid requester, starting at rr_q and wrapping modulo NREQ
  always_comb begin
    // NOTE: give every combinationally written signal a default before any branch;
    // a path that leaves a signal unassigned infers a latch.
    winner    = rr_q;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!any_valid && req_valid[cand[IW-1:0]]) begin
        winner    = cand[IW-1:0];
        any_valid = 1'b1;
      end
    end
  end

  // A locked owner keeps the port; otherwise the round-robin winner is offered it
  assign sel      = (state_q == LOCKED) ? owner_q : winner;
  assign sel_data = req_data[8*sel +: 8];
  assign sel_last = req_last[sel];

  // Ready goes to the owner or winner only. It is held low while reset is asserted
  always_comb begin
    req_ready = '0;
    if (sys_rst_n && (state_q == LOCKED || any_valid)) begin
      req_ready[sel] = load_en;
    end
  end

  assign transfer = |(req_valid & req_ready);
  assign busy     = (state_q == LOCKED) || out_valid;

  // Next-state logic: grant, lock, burst counting and forced release
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    burst_d  = burst_q;
    rr_d     = rr_q;
    grant_d  = grant;
    forced_d = 1'b0;
    if (transfer) begin
      unique case (state_q)
        IDLE: begin
          rr_d = (winner == IW'(NREQ-1)) ? '0 : winner + 1'b1;
          if (!sel_last) begin
            if (MAX_BURST == 1) begin
              forced_d = 1'b1;
            end else begin
              state_d          = LOCKED;
              owner_d          = winner;
              burst_d          = 8'd1;
              grant_d          = '0;
              grant_d[winner]  = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (sel_last) begin
            state_d = IDLE;
            grant_d = '0;
            burst_d = '0;
          end else if (burst_q == 8'(MAX_BURST-1)) begin
            state_d  = IDLE;
            grant_d  = '0;
            burst_d  = '0;
            forced_d = 1'b1;
          end else begin
            burst_d = burst_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register for the arbitration FSM and its bookkeeping
  always_ff @(posedge clk or negedge sys_rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values, independent of statement order.
    if (!sys_rst_n) begin
      state_q        <= IDLE;
      rr_q           <= '0;
      owner_q        <= '0;
      burst_q        <= '0;
      grant          <= '0;
      forced_release <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      owner_q        <= owner_d;
      burst_q        <= burst_d;
      grant          <= grant_d;
      forced_release <= forced_d;
    end
  end

  // Output stage: load on a transfer, drop valid after a drain with no reload, hold on stall
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           sys_rst_n;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     out_data;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           forced_release;

  uart_tx_arbiter #(.NREQ(N), .MAX_BURST(MB)) dut (
    .clk            (clk),
    .sys_rst_n      (sys_rst_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .grant          (grant),
    .busy           (busy),
    .forced_release (forced_release)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } beat_t;

  // Requester sources and the bench's view of traffic
  beat_t      src_q [N][$];
  bit         presented [N];
  logic [N-1:0] en_mask;
  int         valid_pct;
  int         ready_pct;
  logic [7:0] exp_out [$];
  logic [7:0] dut_out [$];
  int         dut_out_cyc [$];
  int         cyc;

  int checks;
  int failures;

  // Values sampled from the DUT at the falling edge
  logic [N-1:0]   s_ready, s_valid, s_last, s_grant;
  logic [N*8-1:0] s_data;
  logic           s_oready, s_out_valid, s_busy, s_fr;
  logic [7:0]     s_out_data;

  // Expected values from the model for the same cycle
  logic [N-1:0] e_ready, e_grant;
  logic         e_out_valid, e_busy, e_fr;
  logic [7:0]   e_out_data;

  // Model: lock owner (-1 = none), bytes sent in this lock, next rr start, output slot
  int         m_owner;
  int         m_cnt;
  int         m_rr;
  bit         m_full;
  bit         m_fr;
  logic [7:0] m_byte;

  task automatic model_reset();
    m_owner = -1;
    m_cnt   = 0;
    m_rr    = 0;
    m_full  = 1'b0;
    m_fr    = 1'b0;
    m_byte  = 8'h00;
  endtask

  // One clock: sample at the falling edge, compute the expected values, then advance the model at the rising edge
  task automatic tick();
    int w;
    @(negedge clk);
    s_ready     = req_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_grant     = grant;
    s_busy      = busy;
    s_fr        = forced_release;
    s_valid     = req_valid;
    s_last      = req_last;
    s_data      = req_data;
    s_oready    = out_ready;

    e_out_valid = m_full;
    e_out_data  = m_byte;
    e_grant     = '0;
    if (m_owner >= 0) e_grant[m_owner] = 1'b1;
    e_busy      = (m_owner >= 0) || m_full;
    e_fr        = m_fr;
    e_ready     = '0;
    w           = -1;
    if (sys_rst_n) begin
      if (m_owner >= 0) begin
        e_ready[m_owner] = !m_full || s_oready;
      end else begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_rr + k) % N;
          if (w < 0 && s_valid[idx]) begin
            w            = idx;
            e_ready[idx] = !m_full || s_oready;
          end
        end
      end
    end

    @(posedge clk);
    cyc++;
    if (s_out_valid && s_oready) begin
      dut_out.push_back(s_out_data);
      dut_out_cyc.push_back(cyc);
    end
    for (int i = 0; i < N; i++) begin
      if (s_valid[i] && s_ready[i] && src_q[i].size() > 0) begin
        void'(src_q[i].pop_front());
        presented[i] = 1'b0;
      end
    end

    m_fr = 1'b0;
    if ((s_valid & e_ready) != '0) begin
      int t;
      t = 0;
      for (int k = 0; k < N; k++) if (s_valid[k] && e_ready[k]) t = k;
      m_full = 1'b1;
      m_byte = s_data[t*8 +: 8];
      exp_out.push_back(m_byte);
      if (m_owner < 0) begin
        m_rr = (t + 1) % N;
        if (!s_last[t]) begin
          if (MB == 1) m_fr = 1'b1;
          else begin
            m_owner = t;
            m_cnt   = 1;
          end
        end
      end else begin
        m_cnt++;
        if (s_last[t]) m_owner = -1;
        else if (m_cnt == MB) begin
          m_owner = -1;
          m_fr    = 1'b1;
        end
      end
    end else if (s_oready) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  // Drive requesters from their queues (a presented byte is held until accepted), then clock once
  task automatic cycle();
    for (int i = 0; i < N; i++) begin
      if (!presented[i] && src_q[i].size() > 0 && en_mask[i] &&
          int'($urandom_range(99)) < valid_pct)
        presented[i] = 1'b1;
      req_valid[i] = presented[i];
      if (presented[i]) begin
        req_data[i*8 +: 8] = src_q[i][0].data;
        req_last[i]        = src_q[i][0].last;
      end else begin
        req_data[i*8 +: 8] = 8'($urandom);
        req_last[i]        = 1'($urandom);
      end
    end
    out_ready = int'($urandom_range(99)) < ready_pct;
    tick();
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      presented[i] = 1'b0;
    end
    en_mask   = '1;
    valid_pct = 100;
    ready_pct = 100;
    @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
    model_reset();
    exp_out.delete();
    dut_out.delete();
    dut_out_cyc.delete();
    cyc = 0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b1;
    req_valid = '1;
    req_last  = '1;
    req_data  = '1;
    out_ready = 1'b1;
    #1 sys_rst_n = 1'b0;
    #2;
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
    checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00)  begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    checks++; if (grant !== 3'b000)    begin failures++; $display("FAIL reset_grant got=%b exp=000", grant); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (forced_release !== 1'b0) begin failures++; $display("FAIL reset_forced got=%b exp=0", forced_release); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 3'b000 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_held ready=%b out_valid=%b exp 000/0", req_ready, out_valid);
    end
  endtask

  task automatic test_single();
    apply_reset();
    src_q[0].push_back({1'b1, 8'h60});
    cycle();
    checks++; if (s_ready !== 3'b001) begin failures++; $display("FAIL single_ready got=%b exp=001", s_ready); end
    checks++; if (s_grant !== 3'b000) begin failures++; $display("FAIL single_grant_t got=%b exp=000", s_grant); end
    cycle();
    checks++; if (s_out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", s_out_valid); end
    checks++; if (s_out_data !== 8'h60) begin failures++; $display("FAIL single_out_data got=%h exp=60", s_out_data); end
    checks++; if (s_grant !== 3'b000)   begin failures++; $display("FAIL single_grant_t1 got=%b exp=000", s_grant); end
    checks++; if (s_busy !== 1'b1)      begin failures++; $display("FAIL single_busy got=%b exp=1", s_busy); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_seq [8];
    apply_reset();
    for (int b = 0; b < 4; b++) begin
      src_q[0].push_back({1'b1, 8'hA0 + 8'(b)});
      src_q[1].push_back({1'b1, 8'hB0 + 8'(b)});
      exp_seq[2*b]   = 8'hA0 + 8'(b);
      exp_seq[2*b+1] = 8'hB0 + 8'(b);
    end
    repeat (9) cycle();
    checks++; if (dut_out.size() !== 8) begin failures++; $display("FAIL rr_count got=%0d exp=8", dut_out.size()); end
    for (int k = 0; k < 8 && k < dut_out.size(); k++) begin
      checks++; if (dut_out[k] !== exp_seq[k]) begin
        failures++; $display("FAIL rr_order[%0d] got=%h exp=%h", k, dut_out[k], exp_seq[k]);
      end
      checks++; if (dut_out_cyc[k] !== dut_out_cyc[0] + k) begin
        failures++; $display("FAIL rr_gap[%0d] got_cycle=%0d exp_cycle=%0d", k, dut_out_cyc[k], dut_out_cyc[0] + k);
      end
    end
  endtask

  task automatic test_lock();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h41; exp_seq[1] = 8'h42; exp_seq[2] = 8'h43; exp_seq[3] = 8'h70;
    apply_reset();
    src_q[1].push_back({1'b0, 8'h41});
    src_q[1].push_back({1'b0, 8'h42});
    src_q[1].push_back({1'b1, 8'h43});
    src_q[0].push_back({1'b1, 8'h70});
    en_mask = 3'b010;
    cycle();
    en_mask = 3'b011;
    cycle();
    checks++; if (s_grant !== 3'b010) begin failures++; $display("FAIL lock_grant got=%b exp=010", s_grant); end
    checks++; if (s_ready !== 3'b010) begin failures++; $display("FAIL lock_ready got=%b exp=010", s_ready); end
    repeat (4) cycle();
    checks++; if (dut_out.size() !== 4) begin failures++; $display("FAIL lock_count got=%0d exp=4", dut_out.size()); end
    for (int k = 0; k < 4 && k < dut_out.size(); k++) begin
      checks++; if (dut_out[k] !== exp_seq[k]) begin
        failures++; $display("FAIL lock_order[%0d] got=%h exp=%h", k, dut_out[k], exp_seq[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h21; exp_seq[2] = 8'h12; exp_seq[3] = 8'h13;
    apply_reset();
    src_q[0].push_back({1'b1, 8'h11});
    src_q[0].push_back({1'b1, 8'h12});
    src_q[0].push_back({1'b1, 8'h13});
    src_q[2].push_back({1'b1, 8'h21});
    cycle();
    ready_pct = 0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      checks++; if (s_out_valid !== 1'b1 || s_out_data !== 8'h11) begin
        failures++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/11", c, s_out_valid, s_out_data);
      end
      checks++; if (s_ready !== 3'b000) begin
        failures++; $display("FAIL bp_ready[%0d] got=%b exp=000", c, s_ready);
      end
    end
    ready_pct = 100;
    repeat (6) cycle();
    checks++; if (dut_out.size() !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", dut_out.size()); end
    for (int k = 0; k < 4 && k < dut_out.size(); k++) begin
      checks++; if (dut_out[k] !== exp_seq[k]) begin
        failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", k, dut_out[k], exp_seq[k]);
      end
    end
  endtask

  task automatic test_max_burst();
    logic [7:0] exp_seq [7];
    int fr_count;
    int fr_cycle;
    logic [N-1:0] fr_ready;
    exp_seq[0] = 8'h80; exp_seq[1] = 8'h81; exp_seq[2] = 8'h82; exp_seq[3] = 8'h83;
    exp_seq[4] = 8'h90; exp_seq[5] = 8'h84; exp_seq[6] = 8'h85;
    apply_reset();
    for (int b = 0; b < 6; b++) src_q[0].push_back({1'b0, 8'h80 + 8'(b)});
    src_q[1].push_back({1'b1, 8'h90});
    fr_count = 0;
    fr_cycle = -1;
    fr_ready = '0;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      if (s_fr) begin
        fr_count++;
        fr_cycle = c;
        fr_ready = s_ready;
      end
    end
    checks++; if (fr_count !== 1) begin failures++; $display("FAIL mb_pulses got=%0d exp=1", fr_count); end
    checks++; if (fr_cycle !== 5) begin failures++; $display("FAIL mb_pulse_cycle got=%0d exp=5", fr_cycle); end
    checks++; if (fr_ready !== 3'b010) begin failures++; $display("FAIL mb_next_winner got=%b exp=010", fr_ready); end
    checks++; if (s_grant !== 3'b001) begin failures++; $display("FAIL mb_idle_owner_grant got=%b exp=001", s_grant); end
    checks++; if (s_busy !== 1'b1) begin failures++; $display("FAIL mb_idle_owner_busy got=%b exp=1", s_busy); end
    checks++; if (dut_out.size() !== 7) begin failures++; $display("FAIL mb_count got=%0d exp=7", dut_out.size()); end
    for (int k = 0; k < 7 && k < dut_out.size(); k++) begin
      checks++; if (dut_out[k] !== exp_seq[k]) begin
        failures++; $display("FAIL mb_order[%0d] got=%h exp=%h", k, dut_out[k], exp_seq[k]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    src_q[1].push_back({1'b0, 8'h31});
    src_q[1].push_back({1'b0, 8'h32});
    src_q[1].push_back({1'b1, 8'h33});
    en_mask = 3'b010;
    cycle();
    cycle();
    checks++; if (s_grant !== 3'b010) begin failures++; $display("FAIL mid_locked got=%b exp=010", s_grant); end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    checks++; if (grant !== 3'b000)   begin failures++; $display("FAIL mid_grant got=%b exp=000", grant); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL mid_ready got=%b exp=000", req_ready); end
    apply_reset();
    src_q[0].push_back({1'b1, 8'h5A});
    src_q[1].push_back({1'b1, 8'h5B});
    cycle();
    checks++; if (s_ready !== 3'b001) begin failures++; $display("FAIL mid_first_winner got=%b exp=001", s_ready); end
    cycle();
    checks++; if (s_out_data !== 8'h5A) begin failures++; $display("FAIL mid_first_byte got=%h exp=5A", s_out_data); end
  endtask

  task automatic test_random();
    int  pending;
    bit  drained;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      int remaining;
      remaining = 30;
      while (remaining > 0) begin
        int plen;
        plen = int'($urandom_range(1, 6));
        for (int b = 0; b < plen; b++) src_q[i].push_back({b == plen - 1, 8'($urandom)});
        remaining -= plen;
      end
    end
    valid_pct = 60;
    ready_pct = 70;
    drained   = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (n == 400) begin
        valid_pct = 100;
        ready_pct = 100;
      end
      pending = 0;
      for (int i = 0; i < N; i++) pending += src_q[i].size();
      if (n >= 400 && pending == 0 && dut_out.size() == exp_out.size()) begin
        drained = 1'b1;
        break;
      end
      cycle();
      checks++; if (s_ready !== e_ready) begin
        failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, s_ready, e_ready);
      end
      checks++; if (s_out_valid !== e_out_valid) begin
        failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, s_out_valid, e_out_valid);
      end
      if (e_out_valid) begin
        checks++; if (s_out_data !== e_out_data) begin
          failures++; $display("FAIL rnd_out_data cyc=%0d got=%h exp=%h", cyc, s_out_data, e_out_data);
        end
      end
      checks++; if (s_grant !== e_grant) begin
        failures++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, s_grant, e_grant);
      end
      checks++; if (s_busy !== e_busy) begin
        failures++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, s_busy, e_busy);
      end
      checks++; if (s_fr !== e_fr) begin
        failures++; $display("FAIL rnd_forced cyc=%0d got=%b exp=%b", cyc, s_fr, e_fr);
      end
    end
    checks++; if (!drained) begin
      failures++; $display("FAIL rnd_drain_timeout got_out=%0d exp_out=%0d", dut_out.size(), exp_out.size());
    end
    checks++; if (dut_out.size() !== exp_out.size()) begin
      failures++; $display("FAIL rnd_stream_len got=%0d exp=%0d", dut_out.size(), exp_out.size());
    end
    for (int k = 0; k < dut_out.size() && k < exp_out.size(); k++) begin
      checks++; if (dut_out[k] !== exp_out[k]) begin
        failures++; $display("FAIL rnd_stream[%0d] got=%h exp=%h", k, dut_out[k], exp_out[k]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_max_burst();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
